// File: rtl/ps2_letter_rx_pkg.sv
// Shared codes, state encodings and the set-2 make-code table for the PS/2 letter receiver.
package ps2_letter_pkg;

    localparam logic [4:0] CODE_RELEASE = 5'd21;
    localparam logic [4:0] CODE_UNKNOWN = 5'd22;
    localparam logic [7:0] SC_BREAK     = 8'hF0;
    localparam logic [7:0] SC_EXT       = 8'hE0;

    typedef enum logic [1:0] {
        DEC_NORMAL  = 2'd0,
        DEC_BRK     = 2'd1,
        DEC_EXT     = 2'd2,
        DEC_EXT_BRK = 2'd3
    } dec_state_t;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_RECV = 1'b1
    } rx_state_t;

    function automatic logic [4:0] scan_to_letter(input logic [7:0] sc);
        logic [4:0] code;
        case (sc)
            8'h1C: code = 5'd0;
            8'h32: code = 5'd1;
            8'h21: code = 5'd2;
            8'h23: code = 5'd3;
            8'h24: code = 5'd4;
            8'h2B: code = 5'd5;
            8'h34: code = 5'd6;
            8'h33: code = 5'd7;
            8'h43: code = 5'd8;
            8'h3B: code = 5'd9;
            8'h4B: code = 5'd10;
            8'h31: code = 5'd11;
            8'h44: code = 5'd12;
            8'h4D: code = 5'd13;
            8'h15: code = 5'd14;
            8'h2D: code = 5'd15;
            8'h1B: code = 5'd16;
            8'h2C: code = 5'd17;
            8'h3C: code = 5'd18;
            8'h35: code = 5'd19;
            8'h1A: code = 5'd20;
            default: code = CODE_UNKNOWN;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ps2_letter_rx_if.sv
// Keyboard pins, decoded letter outputs and FSM debug taps of the PS/2 letter receiver.
interface ps2_letter_rx_if;
    // letter_valid and frame_err are single-cycle strobes with no back-pressure:
    // a consumer must take letter on the cycle letter_valid is high; letter holds between events.
    logic                      kbdclk;
    logic                      kbddat;
    logic [4:0]                letter;
    logic                      letter_valid;
    logic                      frame_err;
    ps2_letter_pkg::rx_state_t  rx_state_dbg;
    ps2_letter_pkg::dec_state_t dec_state_dbg;

    modport master (
        output kbdclk, kbddat,
        input  letter, letter_valid, frame_err, rx_state_dbg, dec_state_dbg
    );

    modport slave (
        input  kbdclk, kbddat,
        output letter, letter_valid, frame_err, rx_state_dbg, dec_state_dbg
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: sync, kbdclk glitch filter, falling-edge detect, shift, stop/parity check, timeout.
// Parity is checked only when PS2_PARITY_CHECK_EN is defined.
module ps2_frame_rx
    import ps2_letter_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbdclk,
    input  logic       kbddat,
    output logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic       err_stb,
    output rx_state_t  state_dbg
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_filt, fall;
    logic [CW-1:0] flt_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= kbdclk;
            clk_s2 <= clk_s1;
            dat_s1 <= kbddat;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered level flips only after FILTER_LEN consecutive differing samples; fall pulses on 1->0.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s2 == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == CW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_s2;
                flt_cnt  <= '0;
                fall     <= clk_filt;
            end else begin
                flt_cnt <= flt_cnt + CW'(1);
            end
        end
    end

    rx_state_t     state, state_n;
    logic [3:0]    bit_cnt, bit_n;
    logic [7:0]    sh, sh_n, byte_n;
    logic [TW-1:0] to_cnt, to_n;
    logic          stb_n, err_n, frame_ok;
`ifdef PS2_PARITY_CHECK_EN
    logic          par, par_n;
    assign frame_ok = dat_s2 && (^{par, sh});
`else
    assign frame_ok = dat_s2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RX_IDLE;
            bit_cnt  <= '0;
            sh       <= '0;
            to_cnt   <= '0;
            rx_byte  <= '0;
            byte_stb <= 1'b0;
            err_stb  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_n;
            sh       <= sh_n;
            to_cnt   <= to_n;
            rx_byte  <= byte_n;
            byte_stb <= stb_n;
            err_stb  <= err_n;
`ifdef PS2_PARITY_CHECK_EN
            par      <= par_n;
`endif
        end
    end

    // bit_cnt 0..7 are data bits, 8 is parity, 9 is the stop bit.
    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        sh_n    = sh;
        to_n    = to_cnt;
        byte_n  = rx_byte;
        stb_n   = 1'b0;
        err_n   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_n   = par;
`endif
        case (state)
            RX_IDLE: begin
                to_n = '0;
                if (fall && !dat_s2) begin
                    state_n = RX_RECV;
                    bit_n   = '0;
                end
            end
            RX_RECV: begin
                if (fall) begin
                    to_n = '0;
                    if (bit_cnt < 4'd8) begin
                        sh_n  = {dat_s2, sh[7:1]};
                        bit_n = bit_cnt + 4'd1;
                    end else if (bit_cnt == 4'd8) begin
`ifdef PS2_PARITY_CHECK_EN
                        par_n = dat_s2;
`endif
                        bit_n = 4'd9;
                    end else begin
                        state_n = RX_IDLE;
                        if (frame_ok) begin
                            stb_n  = 1'b1;
                            byte_n = sh;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    state_n = RX_IDLE;
                    to_n    = '0;
                    err_n   = 1'b1;
                end else begin
                    to_n = to_cnt + TW'(1);
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    assign state_dbg = state;
endmodule

// File: rtl/ps2_letter_rx.sv
// PS/2 scan-code set 2 letter receiver: frame receiver plus make/break/extended decoder.
// Optional parity checking is enabled with PS2_PARITY_CHECK_EN.
module ps2_letter_rx
    import ps2_letter_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input logic         clk,
    input logic         rst,
    ps2_letter_rx_if.slave bus
);
    logic [7:0] rx_byte;
    logic       byte_stb;
    logic       err_stb;
    rx_state_t  rx_state;

    ps2_frame_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_frame (
        .clk      (clk),
        .rst      (rst),
        .kbdclk   (bus.kbdclk),
        .kbddat   (bus.kbddat),
        .rx_byte  (rx_byte),
        .byte_stb (byte_stb),
        .err_stb  (err_stb),
        .state_dbg(rx_state)
    );

    dec_state_t dec, dec_n;
    logic [4:0] letter_q, letter_n;
    logic       valid_q, valid_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            dec      <= DEC_NORMAL;
            letter_q <= CODE_UNKNOWN;
            valid_q  <= 1'b0;
        end else begin
            dec      <= dec_n;
            letter_q <= letter_n;
            valid_q  <= valid_n;
        end
    end

    // Prefix bytes only move the state; every other byte ends the sequence with an event.
    always_comb begin
        dec_n    = dec;
        letter_n = letter_q;
        valid_n  = 1'b0;
        if (byte_stb) begin
            case (dec)
                DEC_NORMAL: begin
                    if (rx_byte == SC_BREAK) begin
                        dec_n = DEC_BRK;
                    end else if (rx_byte == SC_EXT) begin
                        dec_n = DEC_EXT;
                    end else begin
                        letter_n = scan_to_letter(rx_byte);
                        valid_n  = 1'b1;
                    end
                end
                DEC_EXT: begin
                    if (rx_byte == SC_BREAK) begin
                        dec_n = DEC_EXT_BRK;
                    end else begin
                        letter_n = CODE_UNKNOWN;
                        valid_n  = 1'b1;
                        dec_n    = DEC_NORMAL;
                    end
                end
                default: begin
                    letter_n = CODE_RELEASE;
                    valid_n  = 1'b1;
                    dec_n    = DEC_NORMAL;
                end
            endcase
        end
    end

    assign bus.letter        = letter_q;
    assign bus.letter_valid  = valid_q;
    assign bus.frame_err     = err_stb;
    assign bus.rx_state_dbg  = rx_state;
    assign bus.dec_state_dbg = dec;
endmodule

// File: tb/tb_ps2_letter_rx.sv
// Directed bench for ps2_letter_rx: drives PS/2 frames bit by bit and checks letter, strobes and latency.
module tb_ps2_letter_rx;
    localparam int HP = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   vcnt, ecnt, voff;

    ps2_letter_rx_if bus ();

    ps2_letter_rx dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits n cycles, counting strobes; with rec set, notes the cycle of the first valid pulse.
    task automatic wait_cyc(input int n, input bit rec);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (bus.letter_valid === 1'b1) begin
                vcnt++;
                if (rec && voff < 0) voff = i;
            end
            if (bus.frame_err === 1'b1) ecnt++;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic bad_par,
                              input int nbits, input int glitch_bit);
        logic [10:0] bits;
        bits = {stop_bit, (~(^b)) ^ bad_par, b, 1'b0};
        vcnt = 0;
        ecnt = 0;
        voff = -1;
        for (int i = 0; i < nbits; i++) begin
            bus.kbddat = bits[i];
            if (i == glitch_bit) begin
                wait_cyc(HP / 2, 1'b0);
                bus.kbdclk = 1'b0;
                wait_cyc(3, 1'b0);
                bus.kbdclk = 1'b1;
                wait_cyc(HP / 2, 1'b0);
            end else begin
                wait_cyc(HP, 1'b0);
            end
            bus.kbdclk = 1'b0;
            wait_cyc((i == 10) ? 30 : HP, i == 10);
            bus.kbdclk = 1'b1;
        end
        bus.kbddat = 1'b1;
        wait_cyc(HP, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1, 1'b0, 11, -1);
    endtask

    initial begin
        bus.kbdclk = 1'b1;
        bus.kbddat = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_letter", bus.letter, 22);
        check("reset_valid", bus.letter_valid, 0);
        check("reset_err", bus.frame_err, 0);

        send_byte(8'h1C);
        check("make_1c_letter", bus.letter, 0);
        check("make_1c_pulses", vcnt, 1);
        check("make_1c_latency", voff, 12);
        check("make_1c_err", ecnt, 0);

        send_byte(8'hF0);
        check("brk_prefix_pulses", vcnt, 0);
        check("brk_prefix_letter", bus.letter, 0);
        send_byte(8'h1C);
        check("brk_1c_letter", bus.letter, 21);
        check("brk_1c_pulses", vcnt, 1);
        send_byte(8'h4D);
        check("make_4d_letter", bus.letter, 13);
        check("make_4d_pulses", vcnt, 1);

        send_byte(8'hE0);
        check("ext_prefix_pulses", vcnt, 0);
        send_byte(8'h75);
        check("ext_75_letter", bus.letter, 22);
        check("ext_75_pulses", vcnt, 1);
        send_byte(8'hE0);
        send_byte(8'hF0);
        check("extbrk_prefix_pulses", vcnt, 0);
        send_byte(8'h75);
        check("extbrk_75_letter", bus.letter, 21);
        check("extbrk_75_pulses", vcnt, 1);

        send_byte(8'h1C);
        send_byte(8'h1C);
        check("repeat_letter", bus.letter, 0);
        check("repeat_pulses", vcnt, 1);

        send_frame(8'h55, 1'b1, 1'b0, 5, -1);
        wait_cyc(20500, 1'b0);
        check("timeout_err", ecnt, 1);
        check("timeout_pulses", vcnt, 0);
        check("timeout_letter", bus.letter, 0);
        send_byte(8'h24);
        check("after_timeout_letter", bus.letter, 4);
        check("after_timeout_pulses", vcnt, 1);

        send_frame(8'h2C, 1'b1, 1'b0, 11, 4);
        check("glitch_letter", bus.letter, 17);
        check("glitch_pulses", vcnt, 1);
        check("glitch_err", ecnt, 0);

        send_frame(8'h1A, 1'b0, 1'b0, 11, -1);
        check("stop_err", ecnt, 1);
        check("stop_pulses", vcnt, 0);
        check("stop_letter", bus.letter, 17);

        send_frame(8'h35, 1'b1, 1'b1, 11, -1);
`ifdef PS2_PARITY_CHECK_EN
        check("par_err", ecnt, 1);
        check("par_letter", bus.letter, 17);
`else
        check("par_err", ecnt, 0);
        check("par_letter", bus.letter, 19);
`endif
        send_frame(8'hF0, 1'b1, 1'b1, 11, -1);
        send_byte(8'h1C);
`ifdef PS2_PARITY_CHECK_EN
        check("par_f0_letter", bus.letter, 0);
`else
        check("par_f0_letter", bus.letter, 21);
`endif
        check("par_f0_pulses", vcnt, 1);

        send_frame(8'h33, 1'b1, 1'b0, 6, -1);
        rst = 1'b1;
        wait_cyc(3, 1'b0);
        rst = 1'b0;
        wait_cyc(10, 1'b0);
        check("midrst_letter", bus.letter, 22);
        check("midrst_err", ecnt, 0);
        send_byte(8'h1B);
        check("midrst_1b_letter", bus.letter, 16);
        check("midrst_1b_pulses", vcnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
